// File: rtl/lane_queue_tracker_pkg.sv
// Shared traffic-loop definitions: lane indices, legal light patterns, pacing FSM states.
package traffic_pkg;

  localparam int LANES = 8;
  localparam int CNT_W = 8;

  localparam int N1 = 0;
  localparam int N2 = 1;
  localparam int E1 = 2;
  localparam int E2 = 3;
  localparam int S1 = 4;
  localparam int S2 = 5;
  localparam int W1 = 6;
  localparam int W2 = 7;

  localparam logic [7:0] LIGHTS_N   = 8'h03;
  localparam logic [7:0] LIGHTS_E   = 8'h0C;
  localparam logic [7:0] LIGHTS_S   = 8'h30;
  localparam logic [7:0] LIGHTS_W   = 8'h C0;
  localparam logic [7:0] LIGHTS_RED = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    START,
    FLOW
  } pace_state_t;

  function automatic logic light_legal(input logic [7:0] p);
    return (p == LIGHTS_N) || (p == LIGHTS_E) || (p == LIGHTS_S) ||
           (p == LIGHTS_W) || (p == LIGHTS_RED);
  endfunction

endpackage

// File: rtl/lane_queue_tracker_if.sv
// Bus between the queue tracker and the lane selector / environment.
interface lane_queue_tracker_if;
  import traffic_pkg::*;

  logic [LANES-1:0]            arrive;
  logic [7:0]                  lights;
  logic [LANES-1:0][CNT_W-1:0] lane;
  logic [LANES-1:0]            depart;
  logic [LANES-1:0]            overflow;
  logic                        light_err;

  modport master (output arrive, lights, input lane, depart, overflow, light_err);
  modport slave  (input arrive, lights, output lane, depart, overflow, light_err);
endinterface

// File: rtl/lane_queue_tracker_counter.sv
// One lane queue counter: saturating increment, floored decrement, sticky overflow.
module lane_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             dec_taken_o,
  output logic             overflow_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             taken_q, taken_d;
  logic             ovf_q, ovf_set;

  always_comb begin
    count_d = count_q;
    taken_d = 1'b0;
    ovf_set = 1'b0;
    if (dec_i && (count_q != '0)) begin
      // a same-cycle arrival cancels the decrement but the departure still counts
      taken_d = 1'b1;
      if (!inc_i) count_d = count_q - CNT_W'(1);
    end else if (inc_i) begin
      if (count_q == '1) ovf_set = 1'b1;
      else               count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      taken_q <= taken_d;
      ovf_q   <= ovf_q | ovf_set;
    end
  end

  assign count_o     = count_q;
  assign dec_taken_o = taken_q;
  assign overflow_o  = ovf_q;

endmodule

// File: rtl/lane_queue_tracker.sv
// Per-lane queue model: counts arrivals and drains green lanes at a paced rate.
module lane_queue_tracker
  import traffic_pkg::*;
#(
  parameter int LANES         = traffic_pkg::LANES,
  parameter int CNT_W         = traffic_pkg::CNT_W,
  parameter int CLEAR_DELAY   = 2,
  parameter int DEPART_PERIOD = 4
) (
  input  logic          clk,
  input  logic          rst,
  lane_queue_tracker_if.slave bus
);

  localparam int TMR_MAX = (CLEAR_DELAY > DEPART_PERIOD) ? CLEAR_DELAY : DEPART_PERIOD;
  localparam int TMR_W   = ($clog2(TMR_MAX) < 1) ? 1 : $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] CLR_LOAD = TMR_W'(CLEAR_DELAY - 1);
  localparam logic [TMR_W-1:0] DEP_LOAD = TMR_W'(DEPART_PERIOD - 1);

  pace_state_t      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       lights_q, lights_n;
  logic             light_err_q, legal, dep_fire;

  logic [LANES-1:0][CNT_W-1:0] lane_cnt;
  logic [LANES-1:0]            dep_pulse, ovf_flag;

  assign legal    = light_legal(bus.lights);
  assign lights_n = legal ? bus.lights : LIGHTS_RED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      lights_q    <= LIGHTS_RED;
      light_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      lights_q    <= lights_n;
      light_err_q <= light_err_q | ~legal;
    end
  end

  // A pattern change on a would-be departure edge wins: no credit carries over.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    dep_fire = 1'b0;
    if (lights_n == LIGHTS_RED) begin
      state_d = IDLE;
      timer_d = '0;
    end else if (lights_n != lights_q) begin
      state_d = START;
      timer_d = CLR_LOAD;
    end else begin
      case (state_q)
        START, FLOW: begin
          if (timer_q == '0) begin
            dep_fire = 1'b1;
            state_d  = FLOW;
            timer_d  = DEP_LOAD;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .inc_i       (bus.arrive[i]),
      .dec_i       (dep_fire & lights_q[i]),
      .count_o     (lane_cnt[i]),
      .dec_taken_o (dep_pulse[i]),
      .overflow_o  (ovf_flag[i])
    );
  end

  assign bus.lane      = lane_cnt;
  assign bus.depart    = dep_pulse;
  assign bus.overflow  = ovf_flag;
  assign bus.light_err = light_err_q;

endmodule

// File: tb/tb_lane_queue_tracker.sv
// Directed, table-driven bench for lane_queue_tracker with hand-written corner sequences.
module tb_lane_queue_tracker;

  typedef struct {
    logic [7:0]  arr;
    logic [7:0]  lts;
    logic [63:0] lane;
    logic [7:0]  dep;
    logic [7:0]  ovf;
    logic        err;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[24];

  lane_queue_tracker_if bus();

  lane_queue_tracker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [7:0] a, input logic [7:0] l);
    bus.arrive = a;
    bus.lights = l;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.arrive = '0;
    bus.lights = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic vec_t mk(logic [7:0] a, logic [7:0] l, logic [63:0] ln,
                              logic [7:0] d, logic [7:0] o, logic e);
    vec_t v;
    v.arr = a; v.lts = l; v.lane = ln; v.dep = d; v.ovf = o; v.err = e;
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;

    // arrivals, then S green at edge k (vecs[5]) with departures at k+2, k+6, k+10
    vecs[0]  = mk(8'h01, 8'h00, 64'h00_00_00_00_00_00_00_01, 8'h00, 8'h00, 1'b0);
    vecs[1]  = mk(8'h01, 8'h00, 64'h00_00_00_00_00_00_00_02, 8'h00, 8'h00, 1'b0);
    vecs[2]  = mk(8'h01, 8'h00, 64'h00_00_00_00_00_00_00_03, 8'h00, 8'h00, 1'b0);
    vecs[3]  = mk(8'h30, 8'h00, 64'h00_00_01_01_00_00_00_03, 8'h00, 8'h00, 1'b0);
    vecs[4]  = mk(8'h10, 8'h00, 64'h00_00_01_02_00_00_00_03, 8'h00, 8'h00, 1'b0);
    vecs[5]  = mk(8'h00, 8'h30, 64'h00_00_01_02_00_00_00_03, 8'h00, 8'h00, 1'b0);
    vecs[6]  = mk(8'h00, 8'h30, 64'h00_00_01_02_00_00_00_03, 8'h00, 8'h00, 1'b0);
    vecs[7]  = mk(8'h00, 8'h30, 64'h00_00_00_01_00_00_00_03, 8'h30, 8'h00, 1'b0);
    vecs[8]  = mk(8'h00, 8'h30, 64'h00_00_00_01_00_00_00_03, 8'h00, 8'h00, 1'b0);
    vecs[9]  = mk(8'h00, 8'h30, 64'h00_00_00_01_00_00_00_03, 8'h00, 8'h00, 1'b0);
    vecs[10] = mk(8'h00, 8'h30, 64'h00_00_00_01_00_00_00_03, 8'h00, 8'h00, 1'b0);
    vecs[11] = mk(8'h00, 8'h30, 64'h00_00_00_00_00_00_00_03, 8'h10, 8'h00, 1'b0);
    vecs[12] = mk(8'h00, 8'h30, 64'h00_00_00_00_00_00_00_03, 8'h00, 8'h00, 1'b0);
    vecs[13] = mk(8'h00, 8'h30, 64'h00_00_00_00_00_00_00_03, 8'h00, 8'h00, 1'b0);
    vecs[14] = mk(8'h00, 8'h30, 64'h00_00_00_00_00_00_00_03, 8'h00, 8'h00, 1'b0);
    vecs[15] = mk(8'h00, 8'h30, 64'h00_00_00_00_00_00_00_03, 8'h00, 8'h00, 1'b0);
    // illegal pattern: treated as red, sticky error, queued lane4 car never leaves
    vecs[16] = mk(8'h10, 8'h05, 64'h00_00_00_01_00_00_00_03, 8'h00, 8'h00, 1'b1);
    for (int i = 17; i < 23; i++)
      vecs[i] = mk(8'h00, 8'h05, 64'h00_00_00_01_00_00_00_03, 8'h00, 8'h00, 1'b1);
    vecs[23] = mk(8'h00, 8'h00, 64'h00_00_00_01_00_00_00_03, 8'h00, 8'h00, 1'b1);

    do_reset();
    chk("rst_lane", bus.lane, 64'h0);
    chk("rst_depart", {56'h0, bus.depart}, 64'h0);
    chk("rst_overflow", {56'h0, bus.overflow}, 64'h0);
    chk("rst_light_err", {63'h0, bus.light_err}, 64'h0);

    for (int i = 0; i < 24; i++) begin
      step(vecs[i].arr, vecs[i].lts);
      chk($sformatf("vec%0d_lane", i), bus.lane, vecs[i].lane);
      chk($sformatf("vec%0d_depart", i), {56'h0, bus.depart}, {56'h0, vecs[i].dep});
      chk($sformatf("vec%0d_overflow", i), {56'h0, bus.overflow}, {56'h0, vecs[i].ovf});
      chk($sformatf("vec%0d_light_err", i), {63'h0, bus.light_err}, {63'h0, vecs[i].err});
    end

    // asynchronous reset between edges with non-zero state
    #2 rst = 1'b1;
    #1;
    chk("async_rst_lane", bus.lane, 64'h0);
    chk("async_rst_depart", {56'h0, bus.depart}, 64'h0);
    chk("async_rst_overflow", {56'h0, bus.overflow}, 64'h0);
    chk("async_rst_light_err", {63'h0, bus.light_err}, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // saturation on E1, then E green with arrivals on departure edges
    for (int i = 0; i < 255; i++) step(8'h04, 8'h00);
    chk("sat_lane_255", bus.lane, 64'h0000_0000_00FF_0000);
    chk("sat_no_ovf_yet", {56'h0, bus.overflow}, 64'h0);
    step(8'h04, 8'h00);
    chk("sat_lane_hold", bus.lane, 64'h0000_0000_00FF_0000);
    chk("sat_ovf_set", {56'h0, bus.overflow}, 64'h04);
    step(8'h00, 8'h0C);
    step(8'h00, 8'h0C);
    chk("sat_no_early_dep", {56'h0, bus.depart}, 64'h0);
    step(8'h04, 8'h0C);
    chk("sat_arr_dep_lane", bus.lane, 64'h0000_0000_00FF_0000);
    chk("sat_arr_dep_pulse", {56'h0, bus.depart}, 64'h04);
    chk("sat_arr_dep_ovf", {56'h0, bus.overflow}, 64'h04);
    repeat (3) step(8'h00, 8'h0C);
    step(8'h08, 8'h0C);
    chk("e_dep2_lane", bus.lane, 64'h0000_0000_01FE_0000);
    chk("e_dep2_pulse", {56'h0, bus.depart}, 64'h04);
    repeat (3) step(8'h00, 8'h0C);
    step(8'h00, 8'h0C);
    chk("e_dep3_lane", bus.lane, 64'h0000_0000_00FD_0000);
    chk("e_dep3_pulse", {56'h0, bus.depart}, 64'h0C);

    // N green, switched to W one cycle before the N departure
    do_reset();
    step(8'h01, 8'h00);
    step(8'h01, 8'h00);
    step(8'h40, 8'h00);
    step(8'h00, 8'h03);
    step(8'h00, 8'hC0);
    step(8'h00, 8'hC0);
    chk("switch_no_n_lane", bus.lane, 64'h00_01_00_00_00_00_00_02);
    chk("switch_no_n_dep", {56'h0, bus.depart}, 64'h0);
    step(8'h00, 8'hC0);
    chk("switch_w_lane", bus.lane, 64'h00_00_00_00_00_00_00_02);
    chk("switch_w_dep", {56'h0, bus.depart}, 64'h40);
    chk("switch_light_err", {63'h0, bus.light_err}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_queue_tracker.md
# lane_queue_tracker

Per-lane vehicle queue model that closes the traffic-light loop. It counts arrivals on each of the eight lanes and drains cars from the lanes whose lights are green at a paced rate. It presents the resulting 8×8-bit queue counts as the `lane` input of the day-time lane selector and consumes that selector's 8-bit light pattern. It is the producer/consumer at the opposite end of the selector's `lane`/`laneOutput` interface.

## Interface
Parameters:
- `LANES`, 8: number of lanes; fixed at 8, with two lanes per direction.
- `CNT_W`, 8: width of each lane queue counter.
- `CLEAR_DELAY`, 2: cycles from a new green pattern being sampled to the first departure; must be ≥1.
- `DEPART_PERIOD`, 4: cycles between successive departures while green holds; must be ≥1.

Ports:
- `clk` input 1: single clock; all state is updated on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `arrive` input [LANES-1:0]: one-cycle arrival pulse per lane. Bit order is N1,N2,E1,E2,S1,S2,W1,W2 (bit 0 = N1).
- `lights` input [7:0]: light pattern from the selector. Legal patterns are 0x03 (N), 0x0C (E), 0x30 (S), 0xC0 (W) and 0x00 (all red).
- `lane` output [LANES-1:0][CNT_W-1:0]: registered queue count per lane.
- `depart` output [LANES-1:0]: registered one-cycle pulse, set when that lane's count was decremented.
- `overflow` output [LANES-1:0]: sticky flag, set when an arrival was dropped because the lane counter was saturated.
- `light_err` output 1: sticky flag, set when an illegal `lights` pattern was sampled.

## Operation
- `lights` is registered into `lights_q` every cycle. An illegal pattern is registered as 0x00 and sets `light_err`.
- The FSM has three states: IDLE, START and FLOW.
  - IDLE: `lights_q` = 0x00, so no departures occur.
  - On any edge where the sampled legal pattern differs from `lights_q` and is non-zero, the FSM goes to START. From START or FLOW, a change to a different non-zero pattern also goes to START and reloads the timer.
  - START: the timer is loaded with CLEAR_DELAY−1 and counts down to 0. On the edge where it reaches 0, a departure occurs and the FSM goes to FLOW.
  - FLOW: the timer is loaded with DEPART_PERIOD−1 after each departure edge, and a departure occurs each time it expires.
  - A sampled pattern of 0x00 returns the FSM to IDLE from any state.
- Departure event: each lane whose `lights_q` bit is 1 and whose count is >0 decrements by 1 and pulses `depart`. The two lanes of a direction are handled independently.
- Arrival: `count+1`, saturating at 2^CNT_W−1. An arrival at saturation is dropped and sets `overflow[i]`.
- Arrival and departure on the same lane in the same cycle: the count is unchanged and `depart[i]` still pulses. At saturation this rule still holds, so no overflow is flagged.
- A departure scheduled on a lane whose count is 0 is skipped with no pulse. If an arrival lands in that same cycle, the count becomes 1.
- Width rule: all counter arithmetic is CNT_W bits wide, with explicit saturate and floor checks. No wrap-around is allowed in either direction.

## Timing
- Reset values: all `lane` = 0, `depart` = 0, `overflow` = 0, `light_err` = 0, `lights_q` = 0x00, FSM = IDLE, timer = 0. Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- Arrival latency: a pulse in cycle n is visible on `lane` after edge n+1.
- Departures: let edge k be the edge that samples a new green pattern.
  - Departure edges are k+CLEAR_DELAY, then k+CLEAR_DELAY+DEPART_PERIOD·m for m ≥ 1, for as long as the pattern holds.
  - `depart` is high for exactly the cycle following each departure edge.
- The selector's registered output changes at most once per clock. A new pattern always restarts the CLEAR_DELAY wait; no departure credit carries over.

## Structure
- Shared package `traffic_pkg` holds:
  - `LANES` and `CNT_W` defaults.
  - Lane index constants `N1`…`W2`.
  - Legal light pattern constants `LIGHTS_N`, `LIGHTS_E`, `LIGHTS_S`, `LIGHTS_W`, `LIGHTS_RED`.
  - The FSM state enum `pace_state_t` {IDLE, START, FLOW}.
- Sub-module `lane_counter`, instantiated 8 times. Inputs are `inc` and `dec`; outputs are the count, the `dec_taken` pulse and the sticky `overflow`; it implements the saturate and floor rules.
- The top level contains the `lights` register, the legality check, the FSM, the pacing timer, and the fan-out of the departure strobe to each lane as `lights_q[i]`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle with non-zero counts → all outputs are 0 before the next edge.
- Three N1 arrival pulses with `lights`=0x00 → `lane[0]`=3 and no `depart` pulse ever.
- `lane[4]`=2, `lane[5]`=1, `lights`=0x30 sampled at edge k (defaults CLEAR_DELAY=2, DEPART_PERIOD=4):
  - Departure at k+2: counts go to (1,0), and `depart` pulses on lanes 4 and 5.
  - Departure at k+6: counts go to (0,0), and `depart` pulses on lane 4 only.
  - Departure at k+10: no pulses.
- `lane[2]`=255 with continuous arrivals and `lights`=0x00 → `lane[2]` holds at 255 and `overflow[2]`=1. Then apply `lights`=0x0C with an arrival on the departure edge → the count stays 255 and `depart[2]` pulses.
- Pattern switch 0x03→0xC0 one cycle before a scheduled N departure → no N decrement; the first W departure occurs at switch edge + 2.
- `lights`=0x05 (illegal) → treated as all red, `light_err`=1 sticky, no departures.
